// File: rtl/host_bus_master.sv
// host_bus_master: turns OPL3 register-write requests into an address strobe followed by a data strobe on the host bus.
// Optional feature: define HOST_BUS_MASTER_TIMEOUT_EN to abort strobes that never receive an ack.
module host_bus_master #(
    parameter int ASSERT_CYCLES   = 2,
    parameter int RECOVERY_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_bank,
    input  logic [7:0] req_address,
    input  logic [7:0] req_data,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [1:0] address,
    output logic [7:0] dout,
    input  logic       ack_host_wr,
    output logic       busy,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_RECOVER,
        D_SETUP,
        D_STROBE,
        D_RECOVER
    } state_t;

`ifdef HOST_BUS_MASTER_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [8:0] ASSERT_LIMIT   = 9'(ASSERT_CYCLES);
    localparam logic [8:0] RECOVERY_LIMIT = 9'(RECOVERY_CYCLES);
    localparam logic [8:0] TIMEOUT_LIMIT  = 9'(TIMEOUT_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ack_q, ack_d;
    logic       bank_q, bank_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;

    logic       cs_n_q, cs_n_d;
    logic       wr_n_q, wr_n_d;
    logic [1:0] address_q, address_d;
    logic [7:0] dout_q, dout_d;
    logic       req_ready_q, req_ready_d;
    logic       busy_q, busy_d;
    logic       err_timeout_q, err_timeout_d;

    logic [8:0] cnt_inc;
    logic       in_strobe;
    logic       ack_seen;
    logic       assert_done;
    logic       recover_done;
    logic       timed_out;

    // cnt_inc is the number of cycles spent in the current state including this one.
    always_comb begin
        cnt_inc      = {1'b0, cnt_q} + 9'd1;
        in_strobe    = (state_q == A_STROBE) || (state_q == D_STROBE);
        ack_seen     = ack_q || ack_host_wr;
        assert_done  = ack_seen && (cnt_inc >= ASSERT_LIMIT);
        recover_done = cnt_inc >= RECOVERY_LIMIT;
        timed_out    = TIMEOUT_EN && !ack_seen && (cnt_inc >= TIMEOUT_LIMIT);
    end

    always_comb begin
        state_d       = state_q;
        bank_d        = bank_q;
        addr_d        = addr_q;
        data_d        = data_q;
        err_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    bank_d  = req_bank;
                    addr_d  = req_address;
                    data_d  = req_data;
                    state_d = A_SETUP;
                end
            end
            A_SETUP: state_d = A_STROBE;
            A_STROBE: begin
                if (assert_done) begin
                    state_d = A_RECOVER;
                end else if (timed_out) begin
                    // An aborted address phase has no point writing data, so skip straight to recovery.
                    state_d       = D_RECOVER;
                    err_timeout_d = 1'b1;
                end
            end
            A_RECOVER: begin
                if (recover_done) begin
                    state_d = D_SETUP;
                end
            end
            D_SETUP: state_d = D_STROBE;
            D_STROBE: begin
                if (assert_done) begin
                    state_d = D_RECOVER;
                end else if (timed_out) begin
                    state_d       = D_RECOVER;
                    err_timeout_d = 1'b1;
                end
            end
            D_RECOVER: begin
                if (recover_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter and ack flag restart on every state change; acks outside a strobe never latch.
        if (state_d != state_q) begin
            cnt_d = 8'd0;
            ack_d = 1'b0;
        end else begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            ack_d = in_strobe && ack_seen;
        end
    end

    // Outputs are decoded from the next state so the registered bus matches the state register.
    always_comb begin
        cs_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        address_d   = 2'b00;
        dout_d      = 8'h00;
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);

        case (state_d)
            A_SETUP, A_RECOVER: begin
                address_d = {bank_d, 1'b0};
                dout_d    = addr_d;
            end
            A_STROBE: begin
                address_d = {bank_d, 1'b0};
                dout_d    = addr_d;
                cs_n_d    = 1'b0;
                wr_n_d    = 1'b0;
            end
            D_SETUP, D_RECOVER: begin
                address_d = {bank_d, 1'b1};
                dout_d    = data_d;
            end
            D_STROBE: begin
                address_d = {bank_d, 1'b1};
                dout_d    = data_d;
                cs_n_d    = 1'b0;
                wr_n_d    = 1'b0;
            end
            default: begin
                address_d = 2'b00;
                dout_d    = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            ack_q         <= 1'b0;
            bank_q        <= 1'b0;
            addr_q        <= 8'h00;
            data_q        <= 8'h00;
            cs_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
            address_q     <= 2'b00;
            dout_q        <= 8'h00;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ack_q         <= ack_d;
            bank_q        <= bank_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            cs_n_q        <= cs_n_d;
            wr_n_q        <= wr_n_d;
            address_q     <= address_d;
            dout_q        <= dout_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign cs_n        = cs_n_q;
    assign wr_n        = wr_n_q;
    assign rd_n        = 1'b1;
    assign address     = address_q;
    assign dout        = dout_q;
    assign busy        = busy_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_host_bus_master.sv
// Directed bench for host_bus_master: a responder acks strobes, a monitor checks each strobe against a scoreboard.
// Define HOST_BUS_MASTER_TIMEOUT_EN to also run the abort scenario.
module tb_host_bus_master;

    localparam int ASSERT_CYCLES   = 3;
    localparam int RECOVERY_CYCLES = 8;
    localparam int TIMEOUT_CYCLES  = 64;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_bank;
    logic [7:0] req_address;
    logic [7:0] req_data;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic [1:0] address;
    logic [7:0] dout;
    logic       ack_host_wr;
    logic       busy;
    logic       err_timeout;

    host_bus_master #(
        .ASSERT_CYCLES  (ASSERT_CYCLES),
        .RECOVERY_CYCLES(RECOVERY_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_bank   (req_bank),
        .req_address(req_address),
        .req_data   (req_data),
        .cs_n       (cs_n),
        .wr_n       (wr_n),
        .rd_n       (rd_n),
        .address    (address),
        .dout       (dout),
        .ack_host_wr(ack_host_wr),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    typedef struct {
        logic [1:0] addr;
        logic [7:0] dout;
        int         len;
        int         gap;
    } strobe_t;

    strobe_t sb[$];

    int checks;
    int errors;
    int ack_at_a;
    int ack_at_d;
    bit spurious_req;
    bit abort_pending;
    int strobes_done;
    int err_pulses;
    int rd_n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int expLen(input int ack_at);
        if (ack_at == 0) return TIMEOUT_CYCLES;
        return (ack_at > ASSERT_CYCLES) ? ack_at : ASSERT_CYCLES;
    endfunction

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic applyStimulus(input logic bank, input logic [7:0] addr, input logic [7:0] data,
                                 input int a_gap, input bit keep_valid);
        strobe_t e;
        int n;
        req_valid   = 1'b1;
        req_bank    = bank;
        req_address = addr;
        req_data    = data;
        n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) checkOutput("req_ready_wait", req_ready, 1);
        e.addr = {bank, 1'b0};
        e.dout = addr;
        e.len  = expLen(ack_at_a);
        e.gap  = a_gap;
        sb.push_back(e);
        if (ack_at_a != 0) begin
            e.addr = {bank, 1'b1};
            e.dout = data;
            e.len  = expLen(ack_at_d);
            e.gap  = RECOVERY_CYCLES + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!keep_valid) req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || sb.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) checkOutput("idle_wait", busy, 0);
    endtask

    // Responder: one-cycle ack on strobe cycle ack_at_a / ack_at_d (0 = never), plus an optional stray ack.
    initial begin : responder
        int low;
        int target;
        low = 0;
        ack_host_wr = 1'b0;
        forever begin
            @(negedge clk);
            ack_host_wr = 1'b0;
            if (reset) begin
                low = 0;
            end else if (cs_n === 1'b0) begin
                low++;
                target = address[0] ? ack_at_d : ack_at_a;
                if (target != 0 && low == target) ack_host_wr = 1'b1;
            end else begin
                low = 0;
                if (spurious_req) begin
                    ack_host_wr  = 1'b1;
                    spurious_req = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        bit         in_strobe;
        bit         held_bad;
        int         low_len;
        int         gap;
        int         start_gap;
        logic [1:0] s_addr;
        logic [7:0] s_dout;
        strobe_t    e;
        in_strobe = 1'b0;
        held_bad  = 1'b0;
        low_len   = 0;
        gap       = 0;
        start_gap = 0;
        s_addr    = 2'b00;
        s_dout    = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_n !== 1'b1) rd_n_bad++;
            if (err_timeout === 1'b1) err_pulses++;
            if (cs_n === 1'b0) begin
                if (!in_strobe) begin
                    in_strobe = 1'b1;
                    low_len   = 0;
                    start_gap = gap;
                    s_addr    = address;
                    s_dout    = dout;
                    held_bad  = 1'b0;
                end
                low_len++;
                if (address !== s_addr || dout !== s_dout || wr_n !== 1'b0) held_bad = 1'b1;
            end else begin
                if (in_strobe) begin
                    in_strobe = 1'b0;
                    gap       = 0;
                    strobes_done++;
                    if (abort_pending) begin
                        abort_pending = 1'b0;
                    end else begin
                        checkOutput("strobe_expected", sb.size() != 0, 1);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            checkOutput("strobe_address", s_addr, e.addr);
                            checkOutput("strobe_dout", s_dout, e.dout);
                            checkOutput("strobe_length", low_len, e.len);
                            checkOutput("strobe_held", held_bad, 0);
                            if (e.gap >= 0) checkOutput("strobe_gap", start_gap, e.gap);
                        end
                    end
                end
                gap++;
            end
        end
    end

    initial begin : stimulus
        int n;
        int base;
        int rec;
        checks        = 0;
        errors        = 0;
        ack_at_a      = 1;
        ack_at_d      = 1;
        spurious_req  = 1'b0;
        abort_pending = 1'b0;
        strobes_done  = 0;
        err_pulses    = 0;
        rd_n_bad      = 0;
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_bank      = 1'b0;
        req_address   = 8'h00;
        req_data      = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("reset_cs_n", cs_n, 1);
        checkOutput("reset_wr_n", wr_n, 1);
        checkOutput("reset_rd_n", rd_n, 1);
        checkOutput("reset_address", address, 0);
        checkOutput("reset_dout", dout, 0);
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_err", err_timeout, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", req_ready, 1);
        checkOutput("idle_busy", busy, 0);

        // Basic write: ack 4 cycles after the strobe starts.
        ack_at_a = 5;
        ack_at_d = 5;
        applyStimulus(1'b1, 8'h05, 8'h01, -1, 1'b0);
        checkOutput("setup_busy", busy, 1);
        checkOutput("setup_cs_n", cs_n, 1);
        checkOutput("setup_address", address, 2'b10);
        checkOutput("setup_dout", dout, 8'h05);
        checkOutput("setup_req_ready", req_ready, 0);
        waitIdle();
        checkOutput("basic_ready", req_ready, 1);

        // Back-to-back with req_valid held: second accepted in the IDLE cycle after the first finishes.
        ack_at_a = 2;
        ack_at_d = 4;
        applyStimulus(1'b0, 8'h20, 8'hAA, -1, 1'b1);
        applyStimulus(1'b0, 8'h40, 8'hBB, RECOVERY_CYCLES + 2, 1'b0);
        waitIdle();

        // Ack on the very first strobe cycle still holds the strobe for ASSERT_CYCLES.
        ack_at_a = 1;
        ack_at_d = 1;
        applyStimulus(1'b1, 8'h7E, 8'h3C, -1, 1'b0);
        waitIdle();

        // Stray ack during address recovery must not shorten the data strobe.
        ack_at_a = 2;
        ack_at_d = 6;
        base = strobes_done;
        applyStimulus(1'b0, 8'h11, 8'h22, -1, 1'b0);
        n = 0;
        while (strobes_done == base && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("addr_strobe_wait", strobes_done, base + 1);
        spurious_req = 1'b1;
        waitIdle();
        checkOutput("no_err_pulses", err_pulses, 0);

`ifdef HOST_BUS_MASTER_TIMEOUT_EN
        // No ack at all: address strobe aborts, data phase skipped.
        ack_at_a = 0;
        ack_at_d = 0;
        base = strobes_done;
        applyStimulus(1'b0, 8'hB0, 8'h0F, -1, 1'b0);
        n = 0;
        while (cs_n !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (cs_n !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        rec = 0;
        while (req_ready !== 1'b1 && rec < 100) begin
            rec++;
            @(negedge clk);
        end
        checkOutput("timeout_recovery", rec, RECOVERY_CYCLES);
        checkOutput("timeout_err_pulse", err_pulses, 1);
        repeat (30) @(negedge clk);
        checkOutput("timeout_no_data", strobes_done, base + 1);
        checkOutput("timeout_sb_empty", sb.size(), 0);
`endif

        // Reset during the data strobe discards the request silently.
        base = err_pulses;
        ack_at_a = 2;
        ack_at_d = 0;
        applyStimulus(1'b1, 8'h55, 8'h66, -1, 1'b0);
        n = 0;
        while (!(cs_n === 1'b0 && address === 2'b11) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("data_strobe_wait", address, 2'b11);
        sb.delete();
        abort_pending = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_cs_n", cs_n, 1);
        checkOutput("abort_wr_n", wr_n, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_err", err_timeout, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready", req_ready, 1);
        checkOutput("abort_no_err_pulse", err_pulses, base);
        ack_at_d = 3;
        applyStimulus(1'b1, 8'h55, 8'h66, -1, 1'b0);
        waitIdle();

        checkOutput("rd_n_always_high", rd_n_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
